// File: rtl/fetch_stage.sv
// fetch_stage: PC register, loadable instruction memory and the IF/ID pipeline register.
// Priority at every edge: reset > load > redirect > stall > advance.
`timescale 1ns/1ps
module fetch_stage #(
   parameter int          IMEM_DEPTH = 1024,
   parameter logic [31:0] RESET_PC   = 32'h0000_0020
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        write_enable_fm,
   input  logic [31:0] write_addr_fm,
   input  logic [15:0] write_data_fm,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [15:0] instruction,
   output logic [31:0] pc_plus1,
   output logic        if_valid,
   output logic [31:0] pc
);
   localparam int          AW  = $clog2(IMEM_DEPTH);
   localparam logic [15:0] NOP = 16'h0000;
   logic [15:0] imem [IMEM_DEPTH];
   logic [15:0] fetch_word;
   logic [31:0] pc_inc;
   logic        unused_addr_bits;
   // Upper address bits are dropped so both ports wrap around the array.
   assign fetch_word       = imem[pc[AW-1:0]];
   assign pc_inc           = pc + 32'd1;
   assign unused_addr_bits = ^write_addr_fm[31:AW];
   always_ff @(posedge clk)
      if (write_enable_fm) imem[write_addr_fm[AW-1:0]] <= write_data_fm;
   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         instruction <= NOP;
         pc_plus1    <= '0;
         if_valid    <= 1'b0;
      end else if (write_enable_fm) begin
         instruction <= NOP;
         if_valid    <= 1'b0;
      end else if (branch_taken) begin
         pc          <= branch_target;
         instruction <= NOP;
         if_valid    <= 1'b0;
      end else if (!stall) begin
         pc          <= pc_inc;
         instruction <= fetch_word;
         pc_plus1    <= pc_inc;
         if_valid    <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios then random traffic, checked against a rule-level model.
`timescale 1ns/1ps
module tb_fetch_stage;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] RPC   = 32'h0000_0020;
   logic        clk = 1'b0;
   logic        reset, write_enable_fm, stall, branch_taken;
   logic [31:0] write_addr_fm, branch_target;
   logic [15:0] write_data_fm;
   logic [15:0] instruction;
   logic [31:0] pc_plus1, pc;
   logic        if_valid;
   int checks = 0;
   int errors = 0;
   logic [15:0] mem [DEPTH];
   logic [31:0] m_pc = RPC, m_pp1 = '0;
   logic [15:0] m_ins = '0;
   logic        m_v = 1'b0;

   fetch_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset), .write_enable_fm(write_enable_fm),
      .write_addr_fm(write_addr_fm), .write_data_fm(write_data_fm),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .instruction(instruction), .pc_plus1(pc_plus1), .if_valid(if_valid), .pc(pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic we, input logic [31:0] wa, input logic [15:0] wd,
                       input logic st, input logic bt, input logic [31:0] tgt);
      reset = r; write_enable_fm = we; write_addr_fm = wa; write_data_fm = wd;
      stall = st; branch_taken = bt; branch_target = tgt;
      @(posedge clk);
      if (r) begin
         m_pc = RPC; m_ins = 16'h0; m_pp1 = 32'h0; m_v = 1'b0;
      end else if (we) begin
         m_ins = 16'h0; m_v = 1'b0;
      end else if (bt) begin
         m_pc = tgt; m_ins = 16'h0; m_v = 1'b0;
      end else if (!st) begin
         m_ins = mem[m_pc % DEPTH]; m_pp1 = m_pc + 1; m_v = 1'b1; m_pc = m_pc + 1;
      end
      if (we) mem[wa % DEPTH] = wd;
      #1;
      chk("pc", pc, m_pc);
      chk("instruction", {16'h0, instruction}, {16'h0, m_ins});
      chk("pc_plus1", pc_plus1, m_pp1);
      chk("if_valid", {31'h0, if_valid}, {31'h0, m_v});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic load(input logic [31:0] a, input logic [15:0] d);
      step(0, 1, a, d, 0, 0, 0);
   endtask

   initial begin
      step(1, 0, 0, 0, 0, 0, 0);
      chk("reset_pc", pc, 32'h20);
      chk("reset_valid", {31'h0, if_valid}, 32'h0);
      for (int i = 0; i < DEPTH; i++) load(i, 16'($urandom));
      chk("load_pc_frozen", pc, 32'h20);
      load(32'h20, 16'hC95F);
      load(32'h21, 16'h639F);
      load(32'h22, 16'h1F3D);
      load(32'h40, 16'h2177);
      step(1, 0, 0, 0, 0, 0, 0);
      idle(1);
      chk("run0_ins", {16'h0, instruction}, 32'hC95F);
      chk("run0_pp1", pc_plus1, 32'h21);
      chk("run0_valid", {31'h0, if_valid}, 32'h1);
      idle(1);
      chk("run1_ins", {16'h0, instruction}, 32'h639F);
      chk("run1_pp1", pc_plus1, 32'h22);
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0, 0, 1, 0, 0);
         chk("stall_ins", {16'h0, instruction}, 32'h639F);
         chk("stall_pp1", pc_plus1, 32'h22);
         chk("stall_pc", pc, 32'h22);
      end
      idle(1);
      chk("resume_ins", {16'h0, instruction}, 32'h1F3D);
      chk("resume_pp1", pc_plus1, 32'h23);
      step(0, 0, 0, 0, 0, 1, 32'h40);
      chk("redir_ins", {16'h0, instruction}, 32'h0);
      chk("redir_valid", {31'h0, if_valid}, 32'h0);
      chk("redir_pc", pc, 32'h40);
      chk("redir_pp1_hold", pc_plus1, 32'h23);
      idle(1);
      chk("target_ins", {16'h0, instruction}, 32'h2177);
      chk("target_pp1", pc_plus1, 32'h41);
      step(0, 0, 0, 0, 1, 1, 32'h30);
      chk("stall_redir_pc", pc, 32'h30);
      chk("stall_redir_ins", {16'h0, instruction}, 32'h0);
      step(0, 0, 0, 0, 0, 1, DEPTH - 1 + DEPTH);
      idle(1);
      chk("wrap_ins", {16'h0, instruction}, {16'h0, mem[DEPTH-1]});
      chk("wrap_pp1", pc_plus1, 2 * DEPTH);
      step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
      idle(1);
      chk("pc_overflow", pc, 32'h0);
      chk("pp1_overflow", pc_plus1, 32'h0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 1, 1, 32'h55);
      chk("rst_stall_pc", pc, 32'h20);
      chk("rst_stall_valid", {31'h0, if_valid}, 32'h0);
      idle(1);
      chk("mem_intact", {16'h0, instruction}, 32'hC95F);
      load(32'h21, 16'hA001);
      load(32'h22, 16'hA002);
      load(32'h23, 16'hA003);
      chk("midload_pc", pc, 32'h21);
      chk("midload_valid", {31'h0, if_valid}, 32'h0);
      idle(1);
      chk("new0", {16'h0, instruction}, 32'hA001);
      idle(1);
      chk("new1", {16'h0, instruction}, 32'hA002);
      idle(1);
      chk("new2", {16'h0, instruction}, 32'hA003);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] tgt;
         tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
         step($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0,
              ($urandom_range(0, 1) == 0) ? m_pc + $urandom_range(0, 2) : $urandom,
              16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, tgt);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
- REQ-001 SHALL have parameter IMEM_DEPTH, default 1024, meaning the number of 16-bit instruction-memory words (power of two).
- REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0020, meaning the PC value loaded on reset.
- REQ-003 SHALL use one clock and a synchronous, active-high reset: clk and reset.
- REQ-004 SHALL have ports:
  - clk  in  1  system clock, all state updates on the rising edge.
  - reset  in  1  synchronous, active-high reset.
  - write_enable_fm  in  1  program-load write strobe.
  - write_addr_fm  in  32  program-load word address.
  - write_data_fm  in  16  program-load instruction word.
  - stall  in  1  hold request from the decode hazard logic.
  - branch_taken  in  1  redirect request from the ALU stage.
  - branch_target  in  32  redirect word address.
  - instruction  out  16  IF/ID instruction register, to decode.
  - pc_plus1  out  32  IF/ID PC+1 of the held instruction.
  - if_valid  out  1  IF/ID holds a real fetched instruction.
  - pc  out  32  current fetch PC.

Function
- REQ-005 SHALL hold an IMEM_DEPTH x 16 instruction array, indexed by address bits [log2(IMEM_DEPTH)-1:0]; upper bits are ignored, so addresses wrap.
- REQ-006 SHALL write write_data_fm to the word at write_addr_fm on a rising edge with write_enable_fm=1; the write SHALL take effect regardless of reset.
- REQ-007 SHALL read the array combinationally at pc; fetch latency is 1 cycle, pc to instruction.
- REQ-008 SHALL define NOP as 16'h0000.
- REQ-009 SHALL apply, at each rising edge, the first matching case in priority order reset > load > redirect > stall > advance.
- REQ-010 Load mode (write_enable_fm=1): pc SHALL hold, instruction SHALL be set to NOP, and if_valid SHALL be 0.
- REQ-011 Redirect (branch_taken=1):
  - pc SHALL be set to branch_target.
  - instruction SHALL be set to NOP, flushing the wrong-path word.
  - if_valid SHALL be 0.
  - pc_plus1 SHALL hold.
- REQ-012 Redirect SHALL override stall in the same cycle.
- REQ-013 Stall (stall=1): pc, instruction, pc_plus1 and if_valid SHALL all hold.
- REQ-014 Advance:
  - instruction SHALL be set to imem[pc].
  - pc_plus1 SHALL be set to pc+1.
  - if_valid SHALL be 1.
  - pc SHALL be set to pc+1.
- REQ-015 PC arithmetic SHALL be 32-bit modulo 2^32, so 32'hFFFF_FFFF+1 = 0.
- REQ-016 A word written by the load port SHALL be fetchable in the cycle after the write edge.
- REQ-017 Writing the word currently addressed by pc SHALL be legal; because load mode blocks fetch, the stale value is never latched.

Reset
- REQ-018 On a reset edge:
  - pc SHALL be set to RESET_PC.
  - instruction SHALL be set to 16'h0000.
  - pc_plus1 SHALL be set to 0.
  - if_valid SHALL be set to 0.
- REQ-019 Array contents SHALL NOT be cleared by reset.
- REQ-020 A reset asserted mid-stall or mid-redirect SHALL win, and the first fetch after reset deasserts SHALL be from RESET_PC.
- REQ-021 All outputs SHALL be registered; no output SHALL depend combinationally on stall or branch_taken.

Verification
- REQ-022 Load then run:
  - Stimulus: load 16'hC95F at 0x20, 16'h639F at 0x21, 16'h1F3D at 0x22; pulse reset; release.
  - Required response: instruction = C95F, 639F, 1F3D on three successive cycles, with pc_plus1 = 0x21, 0x22, 0x23 and if_valid=1.
- REQ-023 Stall hold:
  - Stimulus: assert stall for 2 cycles while instruction=639F.
  - Required response: instruction, pc_plus1 and pc are unchanged for 2 cycles, and fetch resumes at the next word.
- REQ-024 Redirect:
  - Stimulus: branch_taken=1 with branch_target=0x40, and imem[0x40]=16'h2177.
  - Required response: next cycle instruction=0000 with if_valid=0 and pc=0x40; the following cycle instruction=2177 with pc_plus1=0x41.
- REQ-025 Simultaneous stall and redirect:
  - Stimulus: stall=1 and branch_taken=1 with target 0x30.
  - Required response: pc=0x30 and a NOP bubble.
- REQ-026 Wrap and reset mid-operation:
  - Stimulus: pc=IMEM_DEPTH-1+IMEM_DEPTH; then assert reset during a stall.
  - Required response: imem[IMEM_DEPTH-1] is fetched at that pc; after reset, pc=0x20, if_valid=0 and memory contents are intact.
- REQ-027 Load during run:
  - Stimulus: assert write_enable_fm for 3 cycles mid-program.
  - Required response: pc is frozen, if_valid=0 throughout, and the new words are fetched after release.
